// File: rtl/stopwatch_time_core.sv
// MM:SS.cc BCD stopwatch driven by the centisecond tick, with start/stop, lap freeze and clear.
// Optional STOPWATCH_OVERFLOW_HOLD_EN: saturate at MIN_LIMIT:59.99 and flag overflow instead of wrapping.
module stopwatch_time_core #(
  parameter int MIN_LIMIT = 59  // legal range 1..99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_cs,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic [3:0] cs_t,
  output logic [3:0] cs_o,
  output logic       running,
  output logic       lap_active
`ifdef STOPWATCH_OVERFLOW_HOLD_EN
  ,
  output logic       overflow
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, LAP, STOP} state_t;

  typedef struct packed {
    logic [3:0] min_t;
    logic [3:0] min_o;
    logic [3:0] sec_t;
    logic [3:0] sec_o;
    logic [3:0] cs_t;
    logic [3:0] cs_o;
  } bcd_time_t;

  localparam logic [3:0] MIN_T_LIM = 4'(MIN_LIMIT / 10);
  localparam logic [3:0] MIN_O_LIM = 4'(MIN_LIMIT % 10);

  state_t    state, state_nxt;
  bcd_time_t cnt, cnt_nxt, cnt_inc;
  bcd_time_t snap, snap_nxt;
  bcd_time_t disp;
  logic      count_en;

  // Next-state decode: clear beats start_stop, which beats lap.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else if (start_stop) begin
      case (state)
        IDLE:    state_nxt = RUN;
        RUN:     state_nxt = STOP;
        LAP:     state_nxt = STOP;
        STOP:    state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end else if (lap) begin
      case (state)
        RUN:     state_nxt = LAP;
        LAP:     state_nxt = RUN;
        STOP:    state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // BCD ripple increment; minutes at the limit fold the whole count back to zero.
  always_comb begin
    cnt_inc = cnt;
    if (cnt.cs_o != 4'd9) begin
      cnt_inc.cs_o = cnt.cs_o + 4'd1;
    end else begin
      cnt_inc.cs_o = 4'd0;
      if (cnt.cs_t != 4'd9) begin
        cnt_inc.cs_t = cnt.cs_t + 4'd1;
      end else begin
        cnt_inc.cs_t = 4'd0;
        if (cnt.sec_o != 4'd9) begin
          cnt_inc.sec_o = cnt.sec_o + 4'd1;
        end else begin
          cnt_inc.sec_o = 4'd0;
          if (cnt.sec_t != 4'd5) begin
            cnt_inc.sec_t = cnt.sec_t + 4'd1;
          end else begin
            cnt_inc.sec_t = 4'd0;
            if (cnt.min_t == MIN_T_LIM && cnt.min_o == MIN_O_LIM) begin
              cnt_inc.min_t = 4'd0;
              cnt_inc.min_o = 4'd0;
            end else if (cnt.min_o != 4'd9) begin
              cnt_inc.min_o = cnt.min_o + 4'd1;
            end else begin
              cnt_inc.min_o = 4'd0;
              cnt_inc.min_t = cnt.min_t + 4'd1;
            end
          end
        end
      end
    end
  end

  assign count_en = (state == RUN || state == LAP) && tick_cs && !clear;

`ifdef STOPWATCH_OVERFLOW_HOLD_EN
  logic ovf, ovf_nxt;
  logic at_max;
  assign at_max = (cnt == {MIN_T_LIM, MIN_O_LIM, 4'd5, 4'd9, 4'd9, 4'd9});
`endif

  always_comb begin
    cnt_nxt  = cnt;
    snap_nxt = snap;
`ifdef STOPWATCH_OVERFLOW_HOLD_EN
    ovf_nxt  = ovf;
`endif
    if (clear) begin
      cnt_nxt  = '0;
      snap_nxt = '0;
`ifdef STOPWATCH_OVERFLOW_HOLD_EN
      ovf_nxt  = 1'b0;
`endif
    end else if (!start_stop && lap && state == STOP) begin
      cnt_nxt  = '0;
      snap_nxt = '0;
`ifdef STOPWATCH_OVERFLOW_HOLD_EN
      ovf_nxt  = 1'b0;
`endif
    end else begin
      // Snapshot takes the pre-increment value even when a tick lands in the same cycle.
      if (!start_stop && lap && state == RUN) snap_nxt = cnt;
      if (count_en) begin
`ifdef STOPWATCH_OVERFLOW_HOLD_EN
        if (at_max) ovf_nxt = 1'b1;
        else        cnt_nxt = cnt_inc;
`else
        cnt_nxt = cnt_inc;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      snap <= '0;
    end else begin
      cnt  <= cnt_nxt;
      snap <= snap_nxt;
    end
  end

`ifdef STOPWATCH_OVERFLOW_HOLD_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf <= 1'b0;
    else       ovf <= ovf_nxt;
  end
  assign overflow = ovf;
`endif

  assign disp       = (state == LAP) ? snap : cnt;
  assign min_t      = disp.min_t;
  assign min_o      = disp.min_o;
  assign sec_t      = disp.sec_t;
  assign sec_o      = disp.sec_o;
  assign cs_t       = disp.cs_t;
  assign cs_o       = disp.cs_o;
  assign running    = (state == RUN) || (state == LAP);
  assign lap_active = (state == LAP);

endmodule

// File: tb/tb_stopwatch_time_core.sv
// Bench for stopwatch_time_core: vector table plus scoreboarded sequences against a centisecond model.
`timescale 1ns/1ps
module tb_stopwatch_time_core;

  localparam int MIN_LIMIT = 2;  // small limit keeps the wrap/saturate run short
  localparam int MAX_CS    = (MIN_LIMIT * 60 + 59) * 100 + 99;
`ifdef STOPWATCH_OVERFLOW_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, tick_cs, start_stop, lap, clear;
  logic [3:0] min_t, min_o, sec_t, sec_o, cs_t, cs_o;
  logic running, lap_active, dut_ovf;
  logic [23:0] disp;

  always #5 clk = ~clk;

  stopwatch_time_core #(.MIN_LIMIT(MIN_LIMIT)) dut (
    .clk(clk), .reset(reset), .tick_cs(tick_cs), .start_stop(start_stop),
    .lap(lap), .clear(clear),
    .min_t(min_t), .min_o(min_o), .sec_t(sec_t), .sec_o(sec_o),
    .cs_t(cs_t), .cs_o(cs_o), .running(running), .lap_active(lap_active)
`ifdef STOPWATCH_OVERFLOW_HOLD_EN
    , .overflow(dut_ovf)
`endif
  );
`ifndef STOPWATCH_OVERFLOW_HOLD_EN
  assign dut_ovf = 1'b0;
`endif

  assign disp = {min_t, min_o, sec_t, sec_o, cs_t, cs_o};

  typedef struct {
    logic [23:0] disp;
    logic        run;
    logic        lapa;
    logic        ovf;
  } exp_t;

  typedef struct {
    bit          t, ss, lp, cl;
    logic [23:0] disp;
    logic        run, lapa;
  } vec_t;

  exp_t exp_q[$];
  int checks = 0;
  int passes = 0;

  // Reference model: time held as plain centiseconds.
  int m_st, m_cnt, m_snap;
  bit m_ovf;

  function automatic logic [23:0] to_bcd(int c);
    int m, s, cc;
    m  = c / 6000;
    s  = (c / 100) % 60;
    cc = c % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  function automatic exp_t model_exp();
    exp_t e;
    e.disp = to_bcd(m_st == 2 ? m_snap : m_cnt);
    e.run  = (m_st == 1 || m_st == 2);
    e.lapa = (m_st == 2);
    e.ovf  = m_ovf;
    return e;
  endfunction

  function automatic vec_t mk(bit t, bit ss, bit lp, bit cl, logic [23:0] d, logic r, logic la);
    vec_t v;
    v.t = t; v.ss = ss; v.lp = lp; v.cl = cl; v.disp = d; v.run = r; v.lapa = la;
    return v;
  endfunction

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_snap = 0; m_ovf = 1'b0;
  endtask

  task automatic model_step(input bit t, input bit ss, input bit lp, input bit cl);
    bit inc;
    inc = (m_st == 1 || m_st == 2) && t;
    if (cl) begin
      model_reset();
    end else begin
      if (ss) begin
        case (m_st)
          0: m_st = 1;
          1: m_st = 3;
          2: m_st = 3;
          default: m_st = 1;
        endcase
      end else if (lp) begin
        if (m_st == 1) begin m_snap = m_cnt; m_st = 2; end
        else if (m_st == 2) m_st = 1;
        else if (m_st == 3) begin m_st = 0; m_cnt = 0; m_snap = 0; m_ovf = 1'b0; end
      end
      if (inc) begin
        if (m_cnt == MAX_CS) begin
          if (HOLD) m_ovf = 1'b1;
          else      m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [26:0] act, input logic [26:0] req);
    checks++;
    if (act !== req) $display("FAIL %s: got %h required %h", name, act, req);
    else passes++;
  endtask

  task automatic bcd_legal();
    checks++;
    if (cs_o > 9 || cs_t > 9 || sec_o > 9 || sec_t > 5 || min_o > 9 || min_t > 9)
      $display("FAIL bcd_legal: digits %h", disp);
    else passes++;
  endtask

  task automatic cyc(input bit t, input bit ss, input bit lp, input bit cl,
                     input bit chk, input string name);
    exp_t e;
    @(negedge clk);
    tick_cs = t; start_stop = ss; lap = lp; clear = cl;
    model_step(t, ss, lp, cl);
    if (chk) exp_q.push_back(model_exp());
    @(posedge clk);
    #1;
    tick_cs = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    bcd_legal();
    if (chk) begin
      e = exp_q.pop_front();
      check(name, {disp, running, lap_active, dut_ovf}, {e.disp, e.run, e.lapa, e.ovf});
    end
  endtask

  task automatic ticks(input int n, input string name);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, (i == n - 1), name);
  endtask

  vec_t vecs[16];

  initial begin
    vecs[0]  = mk(1, 0, 0, 0, 24'h000000, 0, 0);  // tick while IDLE ignored
    vecs[1]  = mk(0, 1, 0, 0, 24'h000000, 1, 0);
    vecs[2]  = mk(1, 0, 0, 0, 24'h000001, 1, 0);
    vecs[3]  = mk(1, 1, 0, 0, 24'h000002, 0, 0);  // tick with stop in RUN counts
    vecs[4]  = mk(1, 0, 0, 0, 24'h000002, 0, 0);
    vecs[5]  = mk(0, 1, 0, 0, 24'h000002, 1, 0);
    vecs[6]  = mk(1, 0, 1, 0, 24'h000002, 1, 1);  // snapshot pre-increment
    vecs[7]  = mk(1, 0, 0, 0, 24'h000002, 1, 1);
    vecs[8]  = mk(0, 0, 1, 0, 24'h000004, 1, 0);
    vecs[9]  = mk(0, 0, 1, 0, 24'h000004, 1, 1);
    vecs[10] = mk(0, 1, 0, 0, 24'h000004, 0, 0);  // LAP -> STOP goes live
    vecs[11] = mk(0, 0, 1, 0, 24'h000000, 0, 0);  // STOP+lap clears
    vecs[12] = mk(0, 1, 1, 0, 24'h000000, 1, 0);  // start_stop beats lap
    vecs[13] = mk(1, 0, 0, 0, 24'h000001, 1, 0);
    vecs[14] = mk(1, 1, 0, 1, 24'h000000, 0, 0);  // clear beats everything
    vecs[15] = mk(1, 0, 0, 0, 24'h000000, 0, 0);

    reset = 1'b1; tick_cs = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    model_reset();
    #12;
    check("reset_state", {disp, running, lap_active, dut_ovf}, 27'd0);
    #10 reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      cyc(vecs[i].t, vecs[i].ss, vecs[i].lp, vecs[i].cl, 1'b0, "vec");
      check($sformatf("vec%0d", i), {disp, running, lap_active},
            {vecs[i].disp, vecs[i].run, vecs[i].lapa});
    end

    // 150 ticks then stop; further ticks ignored
    cyc(0, 1, 0, 0, 1, "start");
    ticks(150, "run_150");
    check("run_150_const", {disp, running}, {24'h000150, 1'b1});
    cyc(0, 1, 0, 0, 1, "stop");
    ticks(10, "stopped_ticks");
    check("stopped_const", {disp, running}, {24'h000150, 1'b0});

    // full carry chain 00:59.99 -> 01:00.00
    cyc(0, 0, 0, 1, 1, "clear1");
    cyc(0, 1, 0, 0, 1, "start2");
    ticks(5999, "at_005999");
    check("at_005999_const", disp, 24'h005999);
    ticks(1, "carry_010000");
    check("carry_const", disp, 24'h010000);

    // lap freeze and release
    cyc(0, 0, 0, 1, 1, "clear2");
    cyc(0, 1, 0, 0, 1, "start3");
    ticks(200, "at_000200");
    cyc(0, 0, 1, 0, 1, "lap_in");
    ticks(300, "lap_frozen");
    check("lap_frozen_const", {disp, lap_active}, {24'h000200, 1'b1});
    cyc(0, 0, 1, 0, 1, "lap_out");
    check("lap_live_const", {disp, lap_active}, {24'h000500, 1'b0});

    // same-cycle start_stop + tick, then start_stop + clear
    cyc(0, 0, 0, 1, 1, "clear3");
    cyc(0, 1, 0, 0, 1, "start4");
    ticks(7, "at_000007");
    cyc(1, 1, 0, 0, 1, "stop_tick");
    check("stop_tick_const", {disp, running}, {24'h000008, 1'b0});
    cyc(0, 1, 0, 1, 1, "stop_clear");

    // top of range: wrap or saturate
    cyc(0, 1, 0, 0, 1, "start5");
    ticks(MAX_CS, "at_max");
    check("at_max_const", disp, 24'h025999);
    ticks(1, "past_max");
`ifdef STOPWATCH_OVERFLOW_HOLD_EN
    check("hold_const", {disp, running, dut_ovf}, {24'h025999, 1'b1, 1'b1});
    ticks(3, "hold_more");
    cyc(0, 0, 0, 1, 1, "ovf_clear");
    check("ovf_clear_const", {disp, dut_ovf}, {24'h000000, 1'b0});
`else
    check("wrap_const", {disp, running}, {24'h000000, 1'b1});
    ticks(3, "after_wrap");
`endif

    // asynchronous reset mid-LAP
    cyc(0, 0, 0, 1, 1, "clear4");
    cyc(0, 1, 0, 0, 1, "start6");
    ticks(50, "pre_lap");
    cyc(0, 0, 1, 0, 1, "lap_in2");
    ticks(20, "lap_ticks");
    #2 reset = 1'b1;
    #0.5;
    check("async_reset", {disp, running, lap_active, dut_ovf}, 27'd0);
    #0.5 reset = 1'b0;
    model_reset();
    ticks(5, "post_reset_ticks");
    cyc(0, 1, 0, 0, 1, "post_reset_start");
    ticks(1, "post_reset_count");
    check("post_reset_const", {disp, running}, {24'h000001, 1'b1});

    checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
    else passes++;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
